// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks: default array geometry and
// the input-feature streamer state type.
// No ports; imported by the streamer, its interface and its sub-modules.
package cnn_pkg;

  localparam int ROWS_DEF   = 4;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } if_state_t;

endpackage

// File: rtl/if_streamer_if.sv
// Bundle between the IF controller / IF buffer and the input-feature streamer.
// Control: clr_if, if_read, cfg_base, cfg_len. Buffer: mem_re, mem_addr, mem_rdata.
// Array side: if_data, if_valid, if_done. master = controller/buffer, slave = streamer.
interface if_streamer_if #(
  parameter int DATA_W = cnn_pkg::DATA_W_DEF,
  parameter int ROWS   = cnn_pkg::ROWS_DEF,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 12
);

  logic                     clr_if;
  logic                     if_read;
  logic [ADDR_W-1:0]        cfg_base;
  logic [LEN_W-1:0]         cfg_len;
  logic                     mem_re;
  logic [ADDR_W-1:0]        mem_addr;
  logic [ROWS*DATA_W-1:0]   mem_rdata;
  logic [ROWS*DATA_W-1:0]   if_data;
  logic [ROWS-1:0]          if_valid;
  logic                     if_done;

  modport master (
    output clr_if, if_read, cfg_base, cfg_len, mem_rdata,
    input  mem_re, mem_addr, if_data, if_valid, if_done
  );

  modport slave (
    input  clr_if, if_read, cfg_base, cfg_len, mem_rdata,
    output mem_re, mem_addr, if_data, if_valid, if_done
  );

endinterface

// File: rtl/if_streamer_skew_buffer.sv
// Per-lane delay lines: lane k is delayed k cycles, carrying data plus valid.
// Latency: lane 0 combinational pass-through, lane k = k cycles.
// No backpressure: advances every cycle; synchronous flush clears all valids.
// Ports: clk, flush, in_vld/in_dat (one full vector), out_vld/out_dat (skewed lanes).
module skew_buffer
  import cnn_pkg::*;
#(
  parameter int ROWS   = ROWS_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                   clk,
  input  logic                   flush,
  input  logic                   in_vld,
  input  logic [ROWS*DATA_W-1:0] in_dat,
  output logic [ROWS-1:0]        out_vld,
  output logic [ROWS*DATA_W-1:0] out_dat
);

  for (genvar k = 0; k < ROWS; k++) begin : g_lane
    if (k == 0) begin : g_pass
      assign out_vld[0]          = in_vld;
      assign out_dat[DATA_W-1:0] = in_vld ? in_dat[DATA_W-1:0] : '0;
    end else begin : g_dly
      logic [DATA_W-1:0] dat_sr [k];
      logic [k-1:0]      vld_sr;

      always_ff @(posedge clk) begin
        if (flush) begin
          vld_sr <= '0;
          for (int i = 0; i < k; i++) dat_sr[i] <= '0;
        end else begin
          vld_sr[0] <= in_vld;
          dat_sr[0] <= in_dat[k*DATA_W +: DATA_W];
          for (int i = 1; i < k; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            dat_sr[i] <= dat_sr[i-1];
          end
        end
      end

      // Data is zeroed whenever its valid is low so idle lanes present 0.
      assign out_vld[k]                  = vld_sr[k-1];
      assign out_dat[k*DATA_W +: DATA_W] = vld_sr[k-1] ? dat_sr[k-1] : '0;
    end
  end

endmodule

// File: rtl/if_streamer.sv
// Fetches cfg_len vectors from the IF buffer and streams them skewed into the array.
// Latency: clr_if edge to if_done = len + ROWS + 1 cycles without stalls.
// Backpressure: if_read low stalls issue (bubble enters pipeline); pipeline never stalls.
// Ports: clk, rst (sync, active-high), bus (if_streamer_if.slave).
module if_streamer
  import cnn_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 12
) (
  input  logic         clk,
  input  logic         rst,
  if_streamer_if.slave bus
);

  localparam int DCNT_W = $clog2(ROWS + 1);

  if_state_t         state;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt;
  logic [DCNT_W-1:0] dcnt;
  logic              rd_vld;   // read tag: mem_rdata is valid this cycle
  logic              accept;
  logic              flush;

  assign accept = bus.clr_if && bus.if_read;
  // Any accepted clr_if restarts the job, so in-flight data must not leak out.
  assign flush  = rst || accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      cnt         <= '0;
      dcnt        <= '0;
      rd_vld      <= 1'b0;
      bus.mem_re   <= 1'b0;
      bus.mem_addr <= '0;
      bus.if_done  <= 1'b0;
    end else begin
      bus.mem_re <= 1'b0;
      rd_vld     <= bus.mem_re;
      if (bus.clr_if) bus.if_done <= 1'b0;

      if (accept) begin
        base_q <= bus.cfg_base;
        len_q  <= bus.cfg_len;
        cnt    <= '0;
        dcnt   <= '0;
        rd_vld <= 1'b0;
        if (bus.cfg_len == '0) begin
          state       <= DONE;
          bus.if_done <= 1'b1;
        end else begin
          state <= FETCH;
        end
      end else begin
        case (state)
          FETCH: begin
            if (bus.if_read) begin
              bus.mem_re   <= 1'b1;
              bus.mem_addr <= base_q + ADDR_W'(cnt);
              cnt          <= cnt + LEN_W'(1);
              if (cnt + LEN_W'(1) == len_q) state <= DRAIN;
            end
          end
          DRAIN: begin
            // Counted from the final issue; the last lane of the last vector
            // is on the outputs in the cycle where dcnt reaches ROWS.
            if (dcnt == DCNT_W'(ROWS)) begin
              state       <= DONE;
              bus.if_done <= 1'b1;
            end else begin
              dcnt <= dcnt + DCNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  skew_buffer #(
    .ROWS   (ROWS),
    .DATA_W (DATA_W)
  ) u_skew (
    .clk     (clk),
    .flush   (flush),
    .in_vld  (rd_vld),
    .in_dat  (bus.mem_rdata),
    .out_vld (bus.if_valid),
    .out_dat (bus.if_data)
  );

endmodule
